// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sequencer sharing one SPI master among M requesters
// Ports:
//   CLK_IN, RST_N       clock, synchronous active-low reset
//   req/req_din/req_target/req_cpol/req_cpha   per-requester request and payload
//   gnt, ack, ack_err, rdata                   grant, completion pulse, timeout flag, read word
//   busy, err                                  not-idle, sticky timeout
//   spi_trigger/spi_din/spi_target/spi_cpol/spi_cpha/spi_dout/spi_valid   master side
module spi_arbiter #(
  parameter int M         = 4,
  parameter int N         = 1,
  parameter int C         = 32,
  parameter int CLK_RATIO = 100
) (
  input  logic           CLK_IN,
  input  logic           RST_N,
  input  logic [M-1:0]   req,
  input  logic [M*C-1:0] req_din,
  input  logic [M*N-1:0] req_target,
  input  logic [M-1:0]   req_cpol,
  input  logic [M-1:0]   req_cpha,
  output logic [M-1:0]   gnt,
  output logic [M-1:0]   ack,
  output logic           ack_err,
  output logic [C-1:0]   rdata,
  output logic           busy,
  output logic           err,
  output logic           spi_trigger,
  output logic [C-1:0]   spi_din,
  output logic [N-1:0]   spi_target,
  output logic           spi_cpol,
  output logic           spi_cpha,
  input  logic [C-1:0]   spi_dout,
  input  logic           spi_valid
);
  localparam int FRAME = 2 * (C + 2) * (CLK_RATIO + 1);
  localparam int CW    = $clog2(FRAME + 1);
  localparam int PW    = M > 1 ? $clog2(M) : 1;
  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_START, S_ARM, S_BUSY, S_DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [M-1:0]    gnt_q, gnt_d;
  logic [C-1:0]    rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            ack_err_q, ack_err_d;
  logic [C-1:0]    din_q, din_d;
  logic [N-1:0]    tgt_q, tgt_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic [PW:0]     sum;
  logic [PW-1:0]   win_idx;
  logic            found;
  logic [M-1:0]    win_oh;
  logic [C-1:0]    din_sel;
  logic [N-1:0]    tgt_sel;
  logic            cpol_sel, cpha_sel;
  // scan ptr+1, ptr+2, ... with modulo-M wrap; first requester found wins
  always_comb begin
    win_idx = ptr_q;
    found   = 1'b0;
    sum     = '0;
    for (int k = 1; k <= M; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(M)) sum = sum - (PW+1)'(M);
      if (!found && req[sum[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = sum[PW-1:0];
      end
    end
  end
  always_comb begin
    win_oh  = found ? M'(1) << win_idx : '0;
    din_sel = '0;
    tgt_sel = '0;
    for (int i = 0; i < M; i++) begin
      din_sel = din_sel | (req_din[i*C +: C] & {C{win_oh[i]}});
      tgt_sel = tgt_sel | (req_target[i*N +: N] & {N{win_oh[i]}});
    end
    cpol_sel = |(req_cpol & win_oh);
    cpha_sel = |(req_cpha & win_oh);
  end
  // cnt_q doubles as the post-reset flush counter and the transfer watchdog
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ack_err_d = ack_err_q;
    din_d     = din_q;
    tgt_d     = tgt_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    case (state_q)
      S_FLUSH: begin
        state_d = cnt_q == '0 ? S_IDLE : S_FLUSH;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      S_IDLE: if (found) begin
        gnt_d     = win_oh;
        din_d     = din_sel;
        tgt_d     = tgt_sel;
        cpol_d    = cpol_sel;
        cpha_d    = cpha_sel;
        ptr_d     = win_idx;
        ack_err_d = 1'b0;
        state_d   = S_START;
      end
      S_START: begin
        cnt_d   = CW'(FRAME - 1);
        state_d = S_ARM;
      end
      S_ARM: state_d = S_BUSY;
      S_BUSY: begin
        if (spi_valid) begin
          rdata_d = spi_dout;
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          err_d     = 1'b1;
          ack_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      state_q   <= S_FLUSH;
      cnt_q     <= CW'(FRAME - 1);
      ptr_q     <= PW'(M - 1);
      gnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ack_err_q <= 1'b0;
      din_q     <= '0;
      tgt_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ack_err_q <= ack_err_d;
      din_q     <= din_d;
      tgt_q     <= tgt_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end
  assign gnt         = gnt_q;
  assign ack         = state_q == S_DONE ? gnt_q : '0;
  assign ack_err     = state_q == S_DONE && ack_err_q;
  assign rdata       = rdata_q;
  assign busy        = state_q != S_IDLE;
  assign err         = err_q;
  assign spi_trigger = state_q == S_START;
  assign spi_din     = din_q;
  assign spi_target  = tgt_q;
  assign spi_cpol    = cpol_q;
  assign spi_cpha    = cpha_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized bench for spi_arbiter against a transaction-level model
module tb_spi_arbiter;
  localparam int M = 4, N = 1, C = 32, CLK_RATIO = 5;
  localparam int FRAME = 2 * (C + 2) * (CLK_RATIO + 1);
  localparam logic [C-1:0] FIX = 32'h1234_5678;
  localparam logic [C-1:0] KEY = 32'hC3C3_3C3C;
  logic clk = 1'b0;
  logic RST_N = 1'b0;
  logic [M-1:0] req = '0;
  logic [M*C-1:0] req_din = '0;
  logic [M*N-1:0] req_target = '0;
  logic [M-1:0] req_cpol = '0, req_cpha = '0;
  logic [M-1:0] gnt, ack;
  logic ack_err, busy, err, spi_trigger, spi_cpol, spi_cpha;
  logic [C-1:0] rdata, spi_din;
  logic [N-1:0] spi_target;
  logic [C-1:0] spi_dout = '0;
  logic spi_valid = 1'b0;
  always #5 clk = ~clk;
  spi_arbiter #(.M(M), .N(N), .C(C), .CLK_RATIO(CLK_RATIO)) dut (
    .CLK_IN(clk), .RST_N(RST_N), .req(req), .req_din(req_din), .req_target(req_target),
    .req_cpol(req_cpol), .req_cpha(req_cpha), .gnt(gnt), .ack(ack), .ack_err(ack_err),
    .rdata(rdata), .busy(busy), .err(err), .spi_trigger(spi_trigger), .spi_din(spi_din),
    .spi_target(spi_target), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
    .spi_dout(spi_dout), .spi_valid(spi_valid)
  );
  logic trig_d = 1'b0, pend = 1'b0, mute = 1'b0, fix_en = 1'b0;
  int dly = 0, n_trig = 0, trig_busy = 0;
  logic [C-1:0] din_cap = '0;
  always @(posedge clk) begin
    trig_d <= spi_trigger;
    if (trig_d) spi_valid <= 1'b0;
    if (spi_trigger) begin
      if (pend) trig_busy <= trig_busy + 1;
      pend    <= 1'b1;
      dly     <= $urandom_range(12, 2);
      din_cap <= spi_din;
      n_trig  <= n_trig + 1;
    end else if (pend) begin
      if (dly == 0) begin
        pend <= 1'b0;
        if (!mute) begin
          spi_valid <= 1'b1;
          spi_dout  <= fix_en ? FIX : din_cap ^ KEY;
        end
      end else begin
        dly <= dly - 1;
      end
    end
  end
  int n_chk = 0, n_err = 0, cyc = 0, owner = -1, last_win = M - 1, idle_from = 0;
  int trig_cyc = 0, valid_cyc = -1, n_ack = 0;
  logic prev_valid = 1'b0;
  logic [M-1:0] prev_gnt = '0;
  logic [1:0] hold = '0;
  logic [C-1:0] last_rdata = '0;
  logic err_exp = 1'b0;
  logic [C-1:0] r_din [M];
  logic [N-1:0] r_tgt [M];
  logic r_cpol [M], r_cpha [M];
  int dq[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int rr(input logic [M-1:0] r, input int last);
    for (int k = 1; k <= M; k++) if (r[(last + k) % M]) return (last + k) % M;
    return -1;
  endfunction
  function automatic logic [M-1:0] oh(input int i);
    return i < 0 ? '0 : M'(1) << i;
  endfunction
  task automatic raise(input int i, input logic [C-1:0] d, input logic [N-1:0] t, input logic po, input logic ph);
    r_din[i] = d;
    r_tgt[i] = t;
    r_cpol[i] = po;
    r_cpha[i] = ph;
    req_din[i*C +: C] = d;
    req_target[i*N +: N] = t;
    req_cpol[i] = po;
    req_cpha[i] = ph;
    req[i] = 1'b1;
  endtask
  task automatic tick(input logic [M-1:0] en, input int pct);
    logic [M-1:0] seen, dropped;
    int w;
    logic exp_ack;
    seen = req;
    dropped = '0;
    @(posedge clk);
    #1;
    cyc++;
    if (spi_valid && !prev_valid) valid_cyc = cyc;
    prev_valid = spi_valid;
    if (gnt != 0 && prev_gnt == 0)
      for (int i = M - 1; i >= 0; i--) if (gnt[i]) begin dq.push_back(i); break; end
    prev_gnt = gnt;
    w = (owner < 0 && cyc - 1 >= idle_from) ? rr(seen, last_win) : -1;
    chk("trigger", spi_trigger, w >= 0);
    if (w >= 0) begin
      chk("latch_din", spi_din, r_din[w]);
      chk("latch_target", spi_target, r_tgt[w]);
      hold = {r_cpol[w], r_cpha[w]};
      owner = w;
      last_win = w;
      trig_cyc = cyc;
    end
    chk("cpol_cpha", {spi_cpol, spi_cpha}, hold);
    chk("gnt", gnt, oh(owner));
    exp_ack = owner >= 0 && (mute ? cyc == trig_cyc + FRAME + 2 : (valid_cyc > trig_cyc && cyc == valid_cyc + 1));
    chk("ack", ack, exp_ack ? oh(owner) : '0);
    if (exp_ack) begin
      chk("ack_err", ack_err, mute);
      last_rdata = mute ? '0 : (fix_en ? FIX : r_din[owner] ^ KEY);
      err_exp = err_exp | mute;
      req[owner] = 1'b0;
      dropped[owner] = 1'b1;
      owner = -1;
      idle_from = cyc + 1;
      n_ack++;
    end else begin
      chk("ack_err_quiet", ack_err, 0);
    end
    chk("rdata", rdata, last_rdata);
    chk("err", err, err_exp);
    chk("busy", busy, !(owner < 0 && cyc >= idle_from));
    for (int i = 0; i < M; i++)
      if (en[i] && !req[i] && !dropped[i] && $urandom_range(99) < pct)
        raise(i, $urandom, N'($urandom), 1'($urandom), 1'($urandom));
  endtask
  task automatic drain();
    int b = 0;
    while ((req != 0 || owner >= 0) && b < 3000) begin
      tick('0, 0);
      b++;
    end
    chk("drain_bound", b < 3000, 1);
  endtask
  task automatic do_reset();
    int n = 0;
    logic [M:0] noise = '0;
    RST_N = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", {ack, ack_err}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_trigger", spi_trigger, 0);
    chk("rst_spi", {spi_din, spi_target, spi_cpol, spi_cpha}, 0);
    chk("rst_busy", busy, 1);
    RST_N = 1'b1;
    while (busy && n < FRAME + 100) begin
      n++;
      noise = noise | {ack, spi_trigger};
      @(posedge clk);
      #1;
    end
    chk("flush_len", n, FRAME);
    chk("flush_quiet", noise, 0);
    owner = -1;
    last_win = M - 1;
    hold = '0;
    err_exp = 1'b0;
    last_rdata = '0;
    idle_from = cyc;
    prev_gnt = gnt;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int t0, a0, base, n0, n2, b;
    logic [M-1:0] all;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    fix_en = 1'b1;
    t0 = n_trig;
    a0 = n_ack;
    raise(0, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t1_triggers", n_trig - t0, 1);
    chk("t1_acks", n_ack - a0, 1);
    chk("t1_rdata", rdata, FIX);
    fix_en = 1'b0;
    raise(1, $urandom, 1'b0, 1'b1, 1'b1);
    drain();
    chk("t6_mode", {spi_cpol, spi_cpha}, 2'b11);
    do_reset();
    base = dq.size();
    for (int i = 0; i < M; i++) raise(i, $urandom, N'($urandom), 1'($urandom), 1'($urandom));
    all = '1;
    b = 0;
    while (dq.size() < base + 5 && b < 2000) begin
      tick(all, 100);
      b++;
    end
    drain();
    for (int k = 0; k < 5; k++) chk("t2_order", dq.size() > base + k ? dq[base + k] : -1, exp_order[k]);
    raise(2, $urandom, 1'b0, 1'b0, 1'b1);
    drain();
    base = dq.size();
    raise(0, $urandom, 1'b1, 1'b1, 1'b0);
    raise(2, $urandom, 1'b0, 1'b0, 1'b1);
    b = 0;
    while (dq.size() < base + 100 && b < 5000) begin
      tick(4'b0101, 100);
      b++;
    end
    drain();
    chk("t3_first", dq.size() > base + 1 ? {dq[base], dq[base + 1]} : '1, {32'd0, 32'd2});
    n0 = 0;
    n2 = 0;
    for (int k = base; k < base + 100 && k < dq.size(); k++) begin
      n0 += dq[k] == 0;
      n2 += dq[k] == 2;
    end
    chk("t3_count0", n0, 50);
    chk("t3_count2", n2, 50);
    repeat (1000) tick(all, 10);
    drain();
    mute = 1'b1;
    raise(2, $urandom, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t4_err", err, 1);
    mute = 1'b0;
    raise(3, $urandom, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t4_sticky", err, 1);
    mute = 1'b1;
    raise(1, $urandom, 1'b1, 1'b1, 1'b1);
    b = 0;
    while (owner < 0 && b < 100) begin
      tick('0, 0);
      b++;
    end
    repeat (20) tick('0, 0);
    do_reset();
    mute = 1'b0;
    a0 = n_ack;
    drain();
    chk("t5_reserved", n_ack - a0, 1);
    chk("trigger_overlap", trig_busy, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
